// File: rtl/cnt_stream_checker.sv
// Checks that the sampled counter stream steps by exactly +1, acquires and tracks lock, and reports errors and wraps.
// Latency: every sample shows its effect on the outputs one cycle after its en=1 edge.
// No backpressure: the block samples data_in on every en=1 edge and never stalls the source.
// Ports: clk/rst_n; en strobes data_in; clear zeroes err_count and lost_sticky.
//        Outputs are state, locked, err_pulse, wrap_pulse, err_count and lost_sticky.
module cnt_stream_checker #(
    parameter int WIDTH       = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    output logic [1:0]       state,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             lost_sticky
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACQ  = 2'b01,
        LOCK = 2'b10,
        LOST = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [MW-1:0]    match_q, match_d;
    logic [SW-1:0]    miss_q, miss_d;
    logic [ERR_W-1:0] err_d;
    logic             lost_d, err_pulse_d, wrap_pulse_d;
    logic             hit;

    assign hit = (data_in == exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            wrap_pulse  <= 1'b0;
            err_count   <= '0;
            lost_sticky <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked      <= (state_d == LOCK);
            err_pulse   <= err_pulse_d;
            wrap_pulse  <= wrap_pulse_d;
            err_count   <= err_d;
            lost_sticky <= lost_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        match_d      = match_q;
        miss_d       = miss_q;
        err_d        = err_count;
        lost_d       = lost_sticky;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;

        if (en) begin
            case (state_q)
                IDLE, LOST: begin
                    // First sample (or first after loss) just seeds the expectation.
                    exp_d   = data_in + WIDTH'(1);
                    match_d = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (hit) begin
                        exp_d   = exp_q + WIDTH'(1);
                        match_d = match_q + MW'(1);
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = LOCK;
                            miss_d  = '0;
                        end
                    end else begin
                        // Not yet locked: resync silently, errors are not counted here.
                        exp_d   = data_in + WIDTH'(1);
                        match_d = '0;
                    end
                end
                LOCK: begin
                    // Expectation free-runs in LOCK so one glitch costs one error, not a resync.
                    exp_d = exp_q + WIDTH'(1);
                    if (hit) begin
                        miss_d       = '0;
                        wrap_pulse_d = (data_in == '0);
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count != '1)
                            err_d = err_count + ERR_W'(1);
                        miss_d = miss_q + SW'(1);
                        if (miss_q == SW'(LOSS_THRESH - 1)) begin
                            state_d = LOST;
                            lost_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Clear has priority over any increment or sticky set on the same edge.
        if (clear) begin
            err_d  = '0;
            lost_d = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cnt_stream_checker.sv
// Directed bench for cnt_stream_checker: a default instance and an ERR_W=2 instance share all inputs.
// Expected values are hand-derived constants per step; the narrow instance exercises saturation.
module tb_cnt_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] data_in;
    logic       clear;

    logic [1:0] state_a, state_b;
    logic       locked_a, locked_b;
    logic       errp_a, errp_b;
    logic       wrapp_a, wrapp_b;
    logic [7:0] errc_a;
    logic [1:0] errc_b;
    logic       lost_a, lost_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cnt_stream_checker dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .clear(clear),
        .state(state_a), .locked(locked_a), .err_pulse(errp_a), .wrap_pulse(wrapp_a),
        .err_count(errc_a), .lost_sticky(lost_a)
    );

    cnt_stream_checker #(.ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .clear(clear),
        .state(state_b), .locked(locked_b), .err_pulse(errp_b), .wrap_pulse(wrapp_b),
        .err_count(errc_b), .lost_sticky(lost_b)
    );

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Apply one sample for one clock edge, then settle 1ns past the edge.
    task automatic step(input logic e, input logic [7:0] d, input logic c);
        en      = e;
        data_in = d;
        clear   = c;
        @(posedge clk);
        #1;
        en    = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] e;
        int wraps, drops, pulses;

        en = 1'b0; data_in = 8'h00; clear = 1'b0; rst_n = 1'b0;
        #12;
        check("rst_state", state_a, 0);
        check("rst_locked", locked_a, 0);
        check("rst_errp", errp_a, 0);
        check("rst_wrapp", wrapp_a, 0);
        check("rst_errc", errc_a, 0);
        check("rst_lost", lost_a, 0);
        check("rst_errc_b", errc_b, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Acquire on 0x10..0x20: ACQ after the 1st edge, LOCK after the 5th.
        pulses = 0;
        v = 8'h10;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, v, 1'b0);
            check("acq_state", state_a, (i >= 4) ? 2 : 1);
            check("acq_locked", locked_a, (i >= 4) ? 1 : 0);
            if (errp_a || wrapp_a) pulses++;
            v = v + 8'h01;
        end
        check("acq_pulses", pulses, 0);
        check("acq_errc", errc_a, 0);

        // Run through the wrap 0xFF->0x00 up to 0x02.
        wraps = 0; drops = 0;
        v = 8'h21;
        for (int i = 0; i < 226; i++) begin
            step(1'b1, v, 1'b0);
            if (wrapp_a) wraps++;
            if (!locked_a) drops++;
            if (v == 8'h00) check("wrap_at_00", wrapp_a, 1);
            v = v + 8'h01;
        end
        check("wrap_count", wraps, 1);
        check("wrap_lock_drops", drops, 0);
        check("wrap_errc", errc_a, 0);

        // Advance to exp=0x40, then one glitch.
        while (v != 8'h40) begin
            step(1'b1, v, 1'b0);
            v = v + 8'h01;
        end
        step(1'b1, 8'h99, 1'b0);
        check("glitch_errp", errp_a, 1);
        check("glitch_errc", errc_a, 1);
        check("glitch_locked", locked_a, 1);
        check("glitch_errc_b", errc_b, 1);
        step(1'b1, 8'h41, 1'b0);
        check("glitch_errp_drop", errp_a, 0);
        check("glitch_locked2", locked_a, 1);
        check("glitch_errc2", errc_a, 1);
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h43, 1'b0);

        // Three consecutive bad samples -> LOST.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'h00, 1'b0);
            check("loss_errp", errp_a, 1);
            check("loss_state", state_a, (k == 2) ? 3 : 2);
            check("loss_errc", errc_a, 2 + k);
        end
        check("loss_sticky", lost_a, 1);
        check("loss_locked", locked_a, 0);
        check("loss_errc_b_sat", errc_b, 3);

        // Reacquire from 0x50; sticky holds until clear.
        step(1'b1, 8'h50, 1'b0);
        check("reacq_state", state_a, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'h50 + 8'(i), 1'b0);
            check("reacq_state", state_a, (i == 4) ? 2 : 1);
        end
        check("reacq_sticky_held", lost_a, 1);
        step(1'b0, 8'h00, 1'b1);
        check("clear_sticky", lost_a, 0);
        check("clear_errc", errc_a, 0);
        check("clear_errc_b", errc_b, 0);
        check("clear_state", state_a, 2);

        // Six isolated mismatches: wide counts to 6, narrow saturates at 3.
        e = 8'h55;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, e ^ 8'hFF, 1'b0);
            e = e + 8'h01;
            check("sat_errp_a", errp_a, 1);
            check("sat_errp_b", errp_b, 1);
            check("sat_errc_a", errc_a, k + 1);
            check("sat_errc_b", errc_b, (k + 1 > 3) ? 3 : k + 1);
            step(1'b1, e, 1'b0);
            e = e + 8'h01;
            check("sat_good_errp", errp_b, 0);
            check("sat_good_state", state_b, 2);
        end

        // Clear on a mismatch edge wins over the increment.
        step(1'b1, e ^ 8'hFF, 1'b1);
        e = e + 8'h01;
        check("clrmis_errp", errp_a, 1);
        check("clrmis_errc_a", errc_a, 0);
        check("clrmis_errc_b", errc_b, 0);
        check("clrmis_state", state_a, 2);
        step(1'b1, e ^ 8'hFF, 1'b0);
        e = e + 8'h01;
        check("clrmis_errc_b2", errc_b, 1);
        check("clrmis_state2", state_a, 2);
        // Third miss enters LOST while clear is asserted: sticky ends at 0.
        step(1'b1, e ^ 8'hFF, 1'b1);
        check("clrlost_state", state_a, 3);
        check("clrlost_sticky", lost_a, 0);
        check("clrlost_errc", errc_a, 0);
        check("clrlost_errp", errp_a, 1);
        step(1'b0, 8'hAA, 1'b0);
        check("en0_errp_drop", errp_a, 0);
        check("en0_state_hold", state_a, 3);

        // en toggling: only en=1 samples count.
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            check("tog_state", state_a, (i >= 4) ? 2 : 1);
            if (errp_a || wrapp_a) pulses++;
            step(1'b0, 8'hAA, 1'b0);
            check("tog_hold", state_a, (i >= 4) ? 2 : 1);
            if (errp_a || wrapp_a) pulses++;
        end
        check("tog_pulses", pulses, 0);
        check("tog_errc", errc_a, 0);
        check("tog_locked", locked_a, 1);

        // Asynchronous reset while locked, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state_a, 0);
        check("arst_locked", locked_a, 0);
        check("arst_errp", errp_a, 0);
        check("arst_wrapp", wrapp_a, 0);
        check("arst_errc", errc_a, 0);
        check("arst_lost", lost_a, 0);
        check("arst_state_b", state_b, 0);
        check("arst_locked_b", locked_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
